// File: rtl/frame_byte_tracker_if.sv
// Ingress beat handshake as seen by the frame byte tracker.
// master: the stream front end driving accepted beats; slave: the tracker.
interface frame_byte_tracker_if #(
    parameter int DATA_WIDTH = 64
);
    logic                    beat_accept;
    logic [DATA_WIDTH/8-1:0] beat_keep;
    logic                    beat_last;
    logic                    hdr_ext_en;

    modport master (output beat_accept, beat_keep, beat_last, hdr_ext_en);
    modport slave  (input  beat_accept, beat_keep, beat_last, hdr_ext_en);
endinterface

// File: rtl/frame_byte_tracker.sv
// Per-frame byte tracker: counts keep-masked bytes per accepted beat, finds
// the header end (optionally extended on the first beat), and reports frame
// length plus runt/oversize/keep errors. All outputs are registered.
module frame_byte_tracker #(
    parameter int DATA_WIDTH      = 64,
    parameter int HEADER_BYTES    = 14,
    parameter int EXT_BYTES       = 4,
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    frame_byte_tracker_if.slave                beat,
    output logic [CNT_WIDTH-1:0]               byte_count,
    output logic                               header_done,
    output logic                               header_beat,
    output logic [$clog2(DATA_WIDTH/8):0]      hdr_lane,
    output logic                               frame_done,
    output logic [CNT_WIDTH-1:0]               frame_len,
    output logic                               runt_err,
    output logic                               oversize_err,
    output logic                               keep_err
);
    localparam int BPB    = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(BPB) + 1;
    localparam logic [CNT_WIDTH-1:0] HDR_BASE = CNT_WIDTH'(HEADER_BYTES);
    localparam logic [CNT_WIDTH-1:0] HDR_EXT  = CNT_WIDTH'(HEADER_BYTES + EXT_BYTES);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] hdr_len_q, hdr_len_n;
    logic [CNT_WIDTH-1:0] count_n, len_n;
    logic [LANE_W-1:0]    lane_n;
    logic                 header_done_n, header_beat_n, frame_done_n;
    logic                 runt_n, over_n, keep_err_n;

    logic                 first;
    logic [CNT_WIDTH-1:0] base, hdr_len, new_count;
    logic [CNT_WIDTH:0]   sum;
    logic [LANE_W-1:0]    pop;
    logic [BPB-1:0]       keep_inc;
    logic                 crossing, complete, bad_keep;

    // Beat byte count and mask legality (contiguous from bit0, full unless last, non-empty)
    always_comb begin
        pop = '0;
        for (int i = 0; i < BPB; i++)
            pop = pop + LANE_W'(beat.beat_keep[i]);
        keep_inc = beat.beat_keep + BPB'(1);
        bad_keep = (beat.beat_keep == '0)
                 | ((beat.beat_keep & keep_inc) != '0)
                 | (!beat.beat_last && beat.beat_keep != '1);
    end

    // Saturating count update and header crossing detection for the current beat
    always_comb begin
        first     = (state == IDLE);
        base      = first ? '0 : byte_count;
        hdr_len   = first ? (beat.hdr_ext_en ? HDR_EXT : HDR_BASE) : hdr_len_q;
        sum       = {1'b0, base} + (CNT_WIDTH + 1)'(pop);
        new_count = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        crossing  = (base < hdr_len) && (hdr_len <= new_count);
        complete  = (state == PAYLOAD) || crossing;
    end

    // Next-state and next-output logic; everything holds unless a beat or clr acts
    always_comb begin
        state_n       = state;
        hdr_len_n     = hdr_len_q;
        count_n       = byte_count;
        header_done_n = header_done;
        header_beat_n = 1'b0;
        frame_done_n  = 1'b0;
        lane_n        = hdr_lane;
        len_n         = frame_len;
        runt_n        = runt_err;
        over_n        = oversize_err;
        keep_err_n    = keep_err;
        if (clr) begin
            // abort: the same-cycle beat is dropped, error flags stay for inspection
            state_n       = IDLE;
            count_n       = '0;
            header_done_n = 1'b0;
        end else if (beat.beat_accept) begin
            hdr_len_n  = hdr_len;
            count_n    = new_count;
            runt_n     = first ? 1'b0 : runt_err;
            over_n     = (first ? 1'b0 : oversize_err) | (new_count > MAX_CNT);
            keep_err_n = (first ? 1'b0 : keep_err) | bad_keep;
            if (crossing) begin
                header_beat_n = 1'b1;
                lane_n        = LANE_W'(hdr_len - base);
            end
            if (beat.beat_last) begin
                state_n       = IDLE;
                frame_done_n  = 1'b1;
                len_n         = new_count;
                runt_n        = !complete;
                header_done_n = 1'b0;
            end else begin
                state_n       = complete ? PAYLOAD : HDR;
                header_done_n = complete;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Registered outputs and latched header length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_len_q    <= '0;
            byte_count   <= '0;
            header_done  <= 1'b0;
            header_beat  <= 1'b0;
            hdr_lane     <= '0;
            frame_done   <= 1'b0;
            frame_len    <= '0;
            runt_err     <= 1'b0;
            oversize_err <= 1'b0;
            keep_err     <= 1'b0;
        end else begin
            hdr_len_q    <= hdr_len_n;
            byte_count   <= count_n;
            header_done  <= header_done_n;
            header_beat  <= header_beat_n;
            hdr_lane     <= lane_n;
            frame_done   <= frame_done_n;
            frame_len    <= len_n;
            runt_err     <= runt_n;
            oversize_err <= over_n;
            keep_err     <= keep_err_n;
        end
    end
endmodule

// File: tb/tb_frame_byte_tracker.sv
// Bench for frame_byte_tracker: 64-bit beats, 14-byte header, 4-byte extension,
// 64-byte oversize limit. Completed frames are checked against a queue of
// expected results; per-beat outputs are checked inline in each scenario.
module tb_frame_byte_tracker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] byte_count, frame_len;
    logic        header_done, header_beat, frame_done;
    logic        runt_err, oversize_err, keep_err;
    logic [3:0]  hdr_lane;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int len;
        bit runt;
        bit over;
        bit kerr;
    } exp_t;
    exp_t exp_q[$];

    frame_byte_tracker_if #(.DATA_WIDTH(64)) bif ();

    frame_byte_tracker #(
        .DATA_WIDTH(64), .HEADER_BYTES(14), .EXT_BYTES(4),
        .MAX_FRAME_BYTES(64), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .beat(bif),
        .byte_count(byte_count), .header_done(header_done), .header_beat(header_beat),
        .hdr_lane(hdr_lane), .frame_done(frame_done), .frame_len(frame_len),
        .runt_err(runt_err), .oversize_err(oversize_err), .keep_err(keep_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every frame_done must match the oldest expected frame
    always @(negedge clk) begin : sb
        exp_t e;
        if (rst_n && frame_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL frame_unexpected got frame_len=%0d, expected no frame_done", frame_len);
            end else begin
                e = exp_q.pop_front();
                if (frame_len !== 16'(e.len) || runt_err !== e.runt ||
                    oversize_err !== e.over || keep_err !== e.kerr) begin
                    failures++;
                    $display("FAIL frame_result got len=%0d runt=%b over=%b keep=%b exp len=%0d runt=%b over=%b keep=%b",
                             frame_len, runt_err, oversize_err, keep_err, e.len, e.runt, e.over, e.kerr);
                end
            end
        end
    end

    // One accepted beat; outputs are sampled 1ns after the accepting edge.
    // Between beats the other inputs carry junk that must be ignored.
    task automatic beat(input logic [7:0] keep, input logic last, input logic ext);
        bif.beat_accept = 1'b1;
        bif.beat_keep   = keep;
        bif.beat_last   = last;
        bif.hdr_ext_en  = ext;
        @(posedge clk); #1;
        bif.beat_accept = 1'b0;
        bif.beat_keep   = 8'h00;
        bif.beat_last   = 1'b1;
        bif.hdr_ext_en  = 1'b1;
    endtask

    task automatic push(input int len, input bit runt, input bit over, input bit kerr);
        exp_t e;
        e.len = len; e.runt = runt; e.over = over; e.kerr = kerr;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        bif.beat_accept = 1'b0; bif.beat_keep = 8'h00; bif.beat_last = 1'b0; bif.hdr_ext_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({byte_count, header_done, header_beat, hdr_lane, frame_done, frame_len,
             runt_err, oversize_err, keep_err} !== '0) begin
            failures++;
            $display("FAIL reset_state got count=%0d hd=%b hb=%b lane=%0d fd=%b len=%0d errs=%b%b%b, expected all 0",
                     byte_count, header_done, header_beat, hdr_lane, frame_done, frame_len,
                     runt_err, oversize_err, keep_err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        beat(8'hFF, 1'b0, 1'b0);
        checks++;
        if ({byte_count, header_done, header_beat} !== {16'd8, 1'b0, 1'b0}) begin
            failures++; $display("FAIL basic_beat1 got count=%0d hd=%b hb=%b exp 8 0 0", byte_count, header_done, header_beat);
        end
        beat(8'hFF, 1'b0, 1'b0);
        checks++;
        if ({byte_count, header_done, header_beat, hdr_lane} !== {16'd16, 1'b1, 1'b1, 4'd6}) begin
            failures++; $display("FAIL basic_beat2 got count=%0d hd=%b hb=%b lane=%0d exp 16 1 1 6",
                                 byte_count, header_done, header_beat, hdr_lane);
        end
        push(24, 0, 0, 0);
        beat(8'hFF, 1'b1, 1'b0);
        checks++;
        if ({frame_done, frame_len, header_done, header_beat} !== {1'b1, 16'd24, 1'b0, 1'b0}) begin
            failures++; $display("FAIL basic_last got fd=%b len=%0d hd=%b hb=%b exp 1 24 0 0",
                                 frame_done, frame_len, header_done, header_beat);
        end
        @(posedge clk); #1;
        checks++;
        if ({frame_done, byte_count, hdr_lane} !== {1'b0, 16'd24, 4'd6}) begin
            failures++; $display("FAIL basic_hold got fd=%b count=%0d lane=%0d exp 0 24 6", frame_done, byte_count, hdr_lane);
        end
    endtask

    task automatic test_ext();
        beat(8'hFF, 1'b0, 1'b1);
        beat(8'hFF, 1'b0, 1'b0);
        checks++;
        if ({byte_count, header_done, header_beat} !== {16'd16, 1'b0, 1'b0}) begin
            failures++; $display("FAIL ext_16 got count=%0d hd=%b hb=%b exp 16 0 0", byte_count, header_done, header_beat);
        end
        beat(8'hFF, 1'b0, 1'b0);
        checks++;
        if ({byte_count, header_done, header_beat, hdr_lane} !== {16'd24, 1'b1, 1'b1, 4'd2}) begin
            failures++; $display("FAIL ext_24 got count=%0d hd=%b hb=%b lane=%0d exp 24 1 1 2",
                                 byte_count, header_done, header_beat, hdr_lane);
        end
        push(32, 0, 0, 0);
        beat(8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_keep();
        beat(8'hFF, 1'b0, 1'b0); beat(8'hFF, 1'b0, 1'b0);
        push(19, 0, 0, 0);
        beat(8'h07, 1'b1, 1'b0);
        beat(8'hFF, 1'b0, 1'b0); beat(8'hFF, 1'b0, 1'b0);
        push(18, 0, 0, 1);
        beat(8'h05, 1'b1, 1'b0);
        checks++;
        if ({frame_len, keep_err} !== {16'd18, 1'b1}) begin
            failures++; $display("FAIL keep_gap got len=%0d keep=%b exp 18 1", frame_len, keep_err);
        end
        beat(8'hFF, 1'b0, 1'b0);
        checks++;
        if (keep_err !== 1'b0) begin
            failures++; $display("FAIL keep_clear_first got keep=%b exp 0", keep_err);
        end
        beat(8'h0F, 1'b0, 1'b0);
        checks++;
        if ({byte_count, header_done, keep_err} !== {16'd12, 1'b0, 1'b1}) begin
            failures++; $display("FAIL keep_partial_mid got count=%0d hd=%b keep=%b exp 12 0 1", byte_count, header_done, keep_err);
        end
        push(20, 0, 0, 1);
        beat(8'hFF, 1'b1, 1'b0);
        checks++;
        if ({header_beat, hdr_lane} !== {1'b1, 4'd2}) begin
            failures++; $display("FAIL keep_lane got hb=%b lane=%0d exp 1 2", header_beat, hdr_lane);
        end
        beat(8'hFF, 1'b0, 1'b0); beat(8'hFF, 1'b0, 1'b0);
        push(16, 0, 0, 1);
        beat(8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_runt();
        push(8, 1, 0, 0);
        beat(8'hFF, 1'b1, 1'b0);
        checks++;
        if ({header_done, header_beat, runt_err, frame_done} !== {1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++; $display("FAIL runt_single got hd=%b hb=%b runt=%b fd=%b exp 0 0 1 1",
                                 header_done, header_beat, runt_err, frame_done);
        end
        beat(8'hFF, 1'b0, 1'b0);
        checks++;
        if ({byte_count, runt_err} !== {16'd8, 1'b0}) begin
            failures++; $display("FAIL runt_next got count=%0d runt=%b exp 8 0", byte_count, runt_err);
        end
        push(16, 0, 0, 0);
        beat(8'hFF, 1'b1, 1'b0);
        checks++;
        if ({header_beat, frame_done, header_done, hdr_lane} !== {1'b1, 1'b1, 1'b0, 4'd6}) begin
            failures++; $display("FAIL runt_cross_last got hb=%b fd=%b hd=%b lane=%0d exp 1 1 0 6",
                                 header_beat, frame_done, header_done, hdr_lane);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) push(64, 0, 0, 0);
            beat(8'hFF, i == 8, 1'b0);
        end
        checks++;
        if (oversize_err !== 1'b0) begin
            failures++; $display("FAIL over_exact64 got over=%b exp 0", oversize_err);
        end
        for (int i = 1; i <= 9; i++) begin
            if (i == 9) push(72, 0, 1, 0);
            beat(8'hFF, i == 9, 1'b0);
            if (i == 8) begin
                checks++;
                if ({byte_count, oversize_err} !== {16'd64, 1'b0}) begin
                    failures++; $display("FAIL over_beat8 got count=%0d over=%b exp 64 0", byte_count, oversize_err);
                end
            end
        end
        checks++;
        if ({oversize_err, frame_len} !== {1'b1, 16'd72}) begin
            failures++; $display("FAIL over_beat9 got over=%b len=%0d exp 1 72", oversize_err, frame_len);
        end
        beat(8'hFF, 1'b0, 1'b0);
        checks++;
        if ({byte_count, oversize_err} !== {16'd8, 1'b0}) begin
            failures++; $display("FAIL b2b_restart got count=%0d over=%b exp 8 0", byte_count, oversize_err);
        end
        push(16, 0, 0, 0);
        beat(8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_clr();
        beat(8'hFF, 1'b0, 1'b0);
        beat(8'h0F, 1'b0, 1'b0);
        clr = 1'b1;
        bif.beat_accept = 1'b1; bif.beat_keep = 8'hFF; bif.beat_last = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        bif.beat_accept = 1'b0;
        checks++;
        if ({byte_count, header_done, frame_done, keep_err} !== {16'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL clr_abort got count=%0d hd=%b fd=%b keep=%b exp 0 0 0 1",
                                 byte_count, header_done, frame_done, keep_err);
        end
        beat(8'hFF, 1'b0, 1'b0);
        checks++;
        if ({byte_count, keep_err} !== {16'd8, 1'b0}) begin
            failures++; $display("FAIL clr_restart got count=%0d keep=%b exp 8 0", byte_count, keep_err);
        end
        push(16, 0, 0, 0);
        beat(8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_rst_mid();
        beat(8'hFF, 1'b0, 1'b0);
        beat(8'hFF, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_count, header_done, header_beat, hdr_lane, frame_done, frame_len,
             runt_err, oversize_err, keep_err} !== '0) begin
            failures++; $display("FAIL rst_mid got count=%0d hd=%b hb=%b lane=%0d len=%0d, expected all 0",
                                 byte_count, header_done, header_beat, hdr_lane, frame_len);
        end
        #2 rst_n = 1'b1;
        beat(8'hFF, 1'b0, 1'b0);
        checks++;
        if ({byte_count, header_done} !== {16'd8, 1'b0}) begin
            failures++; $display("FAIL rst_restart got count=%0d hd=%b exp 8 0", byte_count, header_done);
        end
        push(16, 0, 0, 0);
        beat(8'hFF, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ext();
        test_keep();
        test_runt();
        test_back_to_back();
        test_clr();
        test_rst_mid();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL frames_missing got %0d outstanding, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_byte_tracker.md
Name: frame_byte_tracker

Overview:
Per-frame byte tracker for the parser front end; generalises the fixed-threshold header counter.
- Counts valid bytes per accepted beat using a tkeep-style byte mask.
- Detects frame boundaries from beat_last and supports a runtime-extended header length (e.g. VLAN tag).
- Reports the in-beat position where the header ends, plus final frame length and runt/oversize/keep errors.
- Sits between the ingress stream handshake and the header extractor/payload router.

Parameters:
DATA_WIDTH, 64, beat width in bits; multiple of 8, min 16.
HEADER_BYTES, 14, base header length in bytes; must be >= 1.
EXT_BYTES, 4, extra header bytes added when hdr_ext_en is sampled high.
MAX_FRAME_BYTES, 1522, frame length above which oversize_err is raised.
CNT_WIDTH, 16, byte counter width; must hold MAX_FRAME_BYTES + DATA_WIDTH/8.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous abort: drop the current frame, return to IDLE
beat_accept  in  1  one beat transferred this cycle (valid & ready upstream)
beat_keep  in  DATA_WIDTH/8  byte-valid mask, bit0 = lowest byte
beat_last  in  1  accepted beat is the final beat of the frame
hdr_ext_en  in  1  extend header by EXT_BYTES; sampled on the first beat only
byte_count  out  CNT_WIDTH  bytes accepted so far in the current frame
header_done  out  1  header fully received in the current frame
header_beat  out  1  one-cycle pulse: the previous beat completed the header
hdr_lane  out  $clog2(DATA_WIDTH/8)+1  count of header bytes in the completing beat (1..BPB)
frame_done  out  1  one-cycle pulse after the beat_last beat is accepted
frame_len  out  CNT_WIDTH  final byte count; valid while frame_done is high, held afterwards
runt_err  out  1  frame ended before header_done; held until next frame's first beat
oversize_err  out  1  byte_count exceeded MAX_FRAME_BYTES in this frame
keep_err  out  1  beat_keep violated the mask rules in this frame

Behaviour:
- BPB = DATA_WIDTH/8.
- States: IDLE (no frame open), HDR (counting, header incomplete), PAYLOAD (header complete).
- Reset: state IDLE; all outputs 0.
- All outputs are registered and reflect an accepted beat in the cycle after the accepting edge.
- Beat bytes = popcount(beat_keep).
- Next count = byte_count + bytes; saturates at all-ones and never wraps.
- First beat (accepted in IDLE):
  - Count restarts from 0, not from the held byte_count.
  - hdr_len = HEADER_BYTES + (hdr_ext_en ? EXT_BYTES : 0), latched for the whole frame.
  - runt_err, oversize_err and keep_err are cleared.
  - Moves to HDR, or straight to PAYLOAD if the first beat already completes the header.
- Header completion: the crossing beat is the one where old count < hdr_len <= new count.
  - header_done goes to 1 and stays 1 until the frame closes.
  - header_beat pulses for one cycle.
  - hdr_lane = hdr_len - old count; it is held until the next crossing.
  - A crossing with hdr_lane = BPB means the payload starts on the next beat.
- Keep rules; a violating beat sets keep_err, which is sticky for the frame. Bytes are still counted by popcount.
  - The mask must be contiguous from bit0.
  - A non-last beat must be all-ones.
  - An all-zero mask on any beat is an error.
- Oversize: oversize_err is set once the new count exceeds MAX_FRAME_BYTES. Counting continues.
- beat_last accepted:
  - Next cycle: frame_done = 1 and frame_len = new count.
  - runt_err = 1 if the header was not completed by that beat.
  - State returns to IDLE; header_done drops to 0 on the frame_done cycle.
  - byte_count holds its value until the next frame's first beat.
- A single-beat frame (first beat with beat_last) obeys both the first-beat and the last-beat rules.
- A header crossing on the last beat raises header_beat together with frame_done; header_done stays 0.
- Beats accepted back-to-back on consecutive cycles across a frame boundary are handled with no bubble.
- clr:
  - State goes to IDLE; byte_count and header_done go to 0.
  - No frame_done pulse; error flags unchanged.
  - clr wins over a same-cycle beat_accept, and that beat is discarded.
- rst_n low mid-frame: immediate return to the reset values; the next beat starts a new frame.
- beat_keep, beat_last and hdr_ext_en are ignored when beat_accept = 0.

Test Plan:
1. Defaults, hdr_ext_en=0, three full beats with beat_last on beat 3 -> after beat 1: header_done=0, byte_count=8. After beat 2: header_done=1, header_beat pulse, hdr_lane=6. After beat 3: frame_done pulse, frame_len=24.
2. hdr_ext_en=1 on beat 1 (threshold 18), deasserted later, full beats -> header_done=0 after 16 bytes, 1 after 24 bytes, hdr_lane=2. Threshold stays 18.
3. Two full beats, then last beat keep=0x07 -> frame_len=19, keep_err=0. Repeat with keep=0x05 -> frame_len=18, keep_err=1.
4. Single beat keep=0xFF with beat_last -> frame_len=8, runt_err=1, header_done never 1. Next frame starts at byte_count=8 with runt_err cleared.
5. MAX_FRAME_BYTES=64, nine full beats -> oversize_err=1 after beat 9, frame_len=72. Back-to-back next frame -> errors cleared, count restarts.
6. clr plus beat_accept together mid-frame -> byte_count=0, no frame_done. Also rst_n pulse mid-frame -> all outputs 0; next frame counts from 0.
